// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator for a word-addressed data memory
//
// Purpose:
//   Accepts byte-addressed load/store requests (byte/half/word, signed/unsigned).
//   Loads extract and extend a lane of the 32-bit word. Sub-word stores use
//   read-modify-write. Misaligned or reserved-size requests complete at once with
//   err_o and never touch memory. Big-endian lanes: byte offset 0 = bits [31:24].
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_i            request strobe, taken only while idle
//   is_store_i       1 = store, 0 = load
//   size_i           00 byte, 01 half, 10 word, 11 reserved
//   unsigned_i       zero-extend loads when 1
//   byte_addr_i      byte address (ADDR_W+2 bits)
//   store_data_i     right-justified store data
//   busy_o           high whenever not idle
//   done_o, err_o    one-cycle completion pulse and its error flag
//   load_data_o      extended load result, held until the next load completes
//   mem_read_o       memory read strobe
//   mem_write_o      memory write strobe
//   address_o        memory word address
//   write_data_o     memory write data
//   read_data_i      registered memory read data
module mem_access_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              is_store_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W+1:0] byte_addr_i,
  input  logic [31:0]       store_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       load_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [31:0]       write_data_o,
  input  logic [31:0]       read_data_i
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EXT, S_MERGE, S_WR} state_e;

  state_e            state_q;
  logic              done_q, err_q, mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] address_q;
  logic [31:0]       write_data_q, load_data_q;
  logic              is_store_q, unsigned_q;
  logic [1:0]        size_q, off_q;
  logic [15:0]       store_q;

  logic        misalign;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data_d, write_data_d;

  always_comb begin
    misalign = 1'b1;
    case (size_i)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = byte_addr_i[0];
      2'b10:   misalign = |byte_addr_i[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // Lane selection works on the latched offset; ReadData arrives after the request is gone.
  always_comb begin
    byte_lane = 8'h00;
    case (off_q)
      2'd0: byte_lane = read_data_i[31:24];
      2'd1: byte_lane = read_data_i[23:16];
      2'd2: byte_lane = read_data_i[15:8];
      2'd3: byte_lane = read_data_i[7:0];
      default: byte_lane = 8'h00;
    endcase
    half_lane = off_q[1] ? read_data_i[15:0] : read_data_i[31:16];

    load_data_d = read_data_i;
    case (size_q)
      2'b00:   load_data_d = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_data_d = {{16{~unsigned_q & half_lane[15]}}, half_lane};
      default: load_data_d = read_data_i;
    endcase
  end

  // Read-modify-write merge: only the addressed lane is replaced.
  always_comb begin
    write_data_d = read_data_i;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0: write_data_d[31:24] = store_q[7:0];
        2'd1: write_data_d[23:16] = store_q[7:0];
        2'd2: write_data_d[15:8]  = store_q[7:0];
        2'd3: write_data_d[7:0]   = store_q[7:0];
        default: write_data_d = read_data_i;
      endcase
    end else if (off_q[1]) begin
      write_data_d[15:0] = store_q;
    end else begin
      write_data_d[31:16] = store_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      load_data_q  <= '0;
      is_store_q   <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      store_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            if (misalign) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              is_store_q <= is_store_i;
              unsigned_q <= unsigned_i;
              size_q     <= size_i;
              off_q      <= byte_addr_i[1:0];
              store_q    <= store_data_i[15:0];
              address_q  <= byte_addr_i[ADDR_W+1:2];
              if (is_store_i && size_i == 2'b10) begin
                // Full-word store needs no read.
                write_data_q <= store_data_i;
                mem_write_q  <= 1'b1;
                state_q      <= S_WR;
              end else begin
                mem_read_q <= 1'b1;
                state_q    <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          mem_read_q <= 1'b0;
          state_q    <= is_store_q ? S_MERGE : S_EXT;
        end
        S_EXT: begin
          load_data_q <= load_data_d;
          done_q      <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_MERGE: begin
          write_data_q <= write_data_d;
          mem_write_q  <= 1'b1;
          state_q      <= S_WR;
        end
        S_WR: begin
          mem_write_q <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign load_data_o  = load_data_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign address_o    = address_q;
  assign write_data_o = write_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              is_store;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W+1:0] byte_addr;
  logic [31:0]       store_data;
  logic              busy, done, err, mem_read, mem_write;
  logic [31:0]       load_data, write_data;
  logic [ADDR_W-1:0] address;
  logic [31:0]       read_data;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .is_store_i(is_store), .size_i(size),
    .unsigned_i(uns), .byte_addr_i(byte_addr), .store_data_i(store_data),
    .busy_o(busy), .done_o(done), .err_o(err), .load_data_o(load_data),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .address_o(address),
    .write_data_o(write_data), .read_data_i(read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_write) mem[address[7:0]] <= write_data;
    if (mem_read)  read_data <= mem[address[7:0]];
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int e0 = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int rd_lat = 0, wr_lat = 0;
  logic [ADDR_W-1:0] rd_addr = '0, wr_addr = '0;
  logic [31:0] wr_data = '0;

  always begin
    @(negedge clk);
    #2;
    if (mem_read) begin
      rd_cnt  = rd_cnt + 1;
      rd_addr = address;
      rd_lat  = cyc_cnt - e0 + 1;
    end
    if (mem_write) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = address;
      wr_data = write_data;
      wr_lat  = cyc_cnt - e0 + 1;
    end
    if (mem_read && mem_write) both_cnt = both_cnt + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Drives one request for a single edge (E0); returns in cycle E0+1.
  task automatic issue(input logic st, input logic [1:0] sz, input logic u,
                       input logic [ADDR_W+1:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; is_store = st; size = sz; uns = u; byte_addr = a; store_data = d;
    @(negedge clk);
    req = 1'b0;
    e0 = cyc_cnt;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = (done === 1'b1) ? (cyc_cnt - e0 + 1) : 99;
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; is_store = 1'b0; size = 2'b00; uns = 1'b0;
    byte_addr = '0; store_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, err, mem_read, mem_write} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {busy, done, err, mem_read, mem_write});
    end
    n_cmp++; if (address !== '0 || write_data !== '0) begin
      n_fail++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", address, write_data);
    end
    n_cmp++; if (load_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_load_data: got %h expected 00000000", load_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_word();
    int lat, r0;
    issue(1'b1, 2'b10, 1'b0, 18'h14, 32'h8899AABB);
    wait_done(lat);
    n_cmp++; if (lat !== 2 || err !== 1'b0) begin
      n_fail++; $display("FAIL preload_sw: got lat %0d err %b expected lat 2 err 0", lat, err);
    end
    r0 = rd_cnt;
    issue(1'b0, 2'b10, 1'b1, 18'h14, 32'h0);
    wait_done(lat);
    n_cmp++; if (lat !== 3) begin
      n_fail++; $display("FAIL lw_latency: got %0d expected 3", lat);
    end
    n_cmp++; if (load_data !== 32'h8899AABB || err !== 1'b0) begin
      n_fail++; $display("FAIL lw_data: got %h err %b expected 8899aabb err 0", load_data, err);
    end
    n_cmp++; if (rd_cnt - r0 !== 1 || rd_addr !== 16'd5 || rd_lat !== 1) begin
      n_fail++; $display("FAIL lw_read_strobe: got cnt %0d addr %h lat %0d expected 1 0005 1", rd_cnt - r0, rd_addr, rd_lat);
    end
  endtask

  logic [ADDR_W+1:0] v_addr [4];
  logic [1:0]        v_size [4];
  logic              v_uns  [4];
  logic [31:0]       v_exp  [4];

  task automatic test_load_ext();
    int lat;
    v_addr[0] = 18'h15; v_size[0] = 2'b00; v_uns[0] = 1'b0; v_exp[0] = 32'hFFFFFF99;
    v_addr[1] = 18'h15; v_size[1] = 2'b00; v_uns[1] = 1'b1; v_exp[1] = 32'h00000099;
    v_addr[2] = 18'h16; v_size[2] = 2'b01; v_uns[2] = 1'b0; v_exp[2] = 32'hFFFFAABB;
    v_addr[3] = 18'h14; v_size[3] = 2'b01; v_uns[3] = 1'b1; v_exp[3] = 32'h00008899;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, v_size[i], v_uns[i], v_addr[i], 32'h0);
      wait_done(lat);
      n_cmp++; if (load_data !== v_exp[i] || lat !== 3 || err !== 1'b0) begin
        n_fail++; $display("FAIL load_ext[%0d]: got %h lat %0d err %b expected %h lat 3 err 0", i, load_data, lat, err, v_exp[i]);
      end
    end
  endtask

  task automatic test_word_store();
    int lat, r0;
    logic [31:0] ld0;
    r0 = rd_cnt; ld0 = load_data;
    issue(1'b1, 2'b10, 1'b0, 18'h18, 32'hDEADBEEF);
    wait_done(lat);
    n_cmp++; if (lat !== 2 || wr_lat !== 1 || wr_addr !== 16'd6) begin
      n_fail++; $display("FAIL sw_timing: got lat %0d wr_lat %0d addr %h expected 2 1 0006", lat, wr_lat, wr_addr);
    end
    n_cmp++; if (mem[6] !== 32'hDEADBEEF || rd_cnt !== r0 || load_data !== ld0) begin
      n_fail++; $display("FAIL sw_effect: got mem %h reads %0d ld %h expected deadbeef 0 %h", mem[6], rd_cnt - r0, load_data, ld0);
    end
  endtask

  task automatic test_misalign();
    int lat, r0, w0;
    logic [31:0] ld0;
    v_addr[0] = 18'h1A; v_size[0] = 2'b10; v_uns[0] = 1'b1;
    v_addr[1] = 18'h15; v_size[1] = 2'b01; v_uns[1] = 1'b0;
    v_addr[2] = 18'h16; v_size[2] = 2'b10; v_uns[2] = 1'b0;
    v_addr[3] = 18'h14; v_size[3] = 2'b11; v_uns[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r0 = rd_cnt; w0 = wr_cnt; ld0 = load_data;
      issue(v_uns[i], v_size[i], 1'b0, v_addr[i], 32'h11223344);
      wait_done(lat);
      n_cmp++; if (lat !== 1 || err !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL misalign[%0d]: got lat %0d err %b busy %b expected 1 1 0", i, lat, err, busy);
      end
      @(negedge clk); #3;
      n_cmp++; if (rd_cnt !== r0 || wr_cnt !== w0 || mem[6] !== 32'hDEADBEEF || load_data !== ld0 || done !== 1'b0) begin
        n_fail++; $display("FAIL misalign_side[%0d]: got rd %0d wr %0d mem6 %h ld %h done %b", i, rd_cnt - r0, wr_cnt - w0, mem[6], load_data, done);
      end
    end
  endtask

  task automatic test_sub_store();
    int lat, w0;
    logic [31:0] ld0;
    w0 = wr_cnt; ld0 = load_data;
    issue(1'b1, 2'b00, 1'b0, 18'h17, 32'h123456CC);
    wait_done(lat);
    n_cmp++; if (lat !== 4 || err !== 1'b0) begin
      n_fail++; $display("FAIL sb_latency: got %0d err %b expected 4 err 0", lat, err);
    end
    n_cmp++; if (wr_cnt - w0 !== 1 || wr_lat !== 3 || wr_addr !== 16'd5 || wr_data !== 32'h8899AACC) begin
      n_fail++; $display("FAIL sb_write: got cnt %0d lat %0d addr %h data %h expected 1 3 0005 8899aacc", wr_cnt - w0, wr_lat, wr_addr, wr_data);
    end
    n_cmp++; if (load_data !== ld0) begin
      n_fail++; $display("FAIL sb_load_data_kept: got %h expected %h", load_data, ld0);
    end
    issue(1'b0, 2'b10, 1'b0, 18'h14, 32'h0);
    wait_done(lat);
    n_cmp++; if (load_data !== 32'h8899AACC) begin
      n_fail++; $display("FAIL sb_readback: got %h expected 8899aacc", load_data);
    end
  endtask

  task automatic test_back_to_back();
    int lat, r0;
    r0 = rd_cnt;
    @(negedge clk);
    req = 1'b1; is_store = 1'b0; size = 2'b10; uns = 1'b0; byte_addr = 18'h14;
    @(negedge clk);
    e0 = cyc_cnt;
    wait_done(lat);
    n_cmp++; if (lat !== 3 || load_data !== 32'h8899AACC || rd_cnt - r0 !== 1) begin
      n_fail++; $display("FAIL held_req: got lat %0d data %h reads %0d expected 3 8899aacc 1", lat, load_data, rd_cnt - r0);
    end
    size = 2'b00; uns = 1'b1; byte_addr = 18'h15;
    @(negedge clk);
    req = 1'b0;
    e0 = cyc_cnt;
    n_cmp++; if (busy !== 1'b1 || mem_read !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got busy %b mem_read %b expected 1 1", busy, mem_read);
    end
    wait_done(lat);
    n_cmp++; if (lat !== 3 || load_data !== 32'h00000099 || rd_cnt - r0 !== 2 || rd_lat !== 1) begin
      n_fail++; $display("FAIL b2b_second: got lat %0d data %h reads %0d rd_lat %0d expected 3 00000099 2 1", lat, load_data, rd_cnt - r0, rd_lat);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, w0;
    issue(1'b1, 2'b10, 1'b0, 18'h14, 32'h8899AABB);
    wait_done(lat);
    w0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 18'h17, 32'h123456CC);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, done, err, mem_read, mem_write} !== 5'b0 || address !== '0 || write_data !== '0 || load_data !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %b addr %h wd %h ld %h expected all zero", {busy, done, err, mem_read, mem_write}, address, write_data, load_data);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    n_cmp++; if (wr_cnt !== w0 || mem[5] !== 32'h8899AABB) begin
      n_fail++; $display("FAIL rst_mid_mem: got writes %0d mem5 %h expected 0 8899aabb", wr_cnt - w0, mem[5]);
    end
    n_cmp++; if (both_cnt !== 0) begin
      n_fail++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_word_store();
    test_misalign();
    test_sub_store();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
